// File: rtl/turf_pkg.sv
// rtl/turf_pkg.sv - shared constants and types for the turf_tally territory scanner
package turf_pkg;

   localparam int X_W         = 8;
   localparam int Y_W         = 7;
   localparam int ADDR_W      = 15;
   localparam int COUNT_W     = 15;
   localparam int NUM_PLAYERS = 4;

   localparam logic [2:0] P1_COL    = 3'b001;
   localparam logic [2:0] P2_COL    = 3'b010;
   localparam logic [2:0] P3_COL    = 3'b100;
   localparam logic [2:0] P4_COL    = 3'b110;
   localparam logic [2:0] TIMER_COL = 3'b111;
   localparam logic [2:0] EMPTY_COL = 3'b000;

   typedef enum logic [1:0] {
      WIN_P1 = 2'd0,
      WIN_P2 = 2'd1,
      WIN_P3 = 2'd2,
      WIN_P4 = 2'd3
   } winner_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_DECIDE
   } state_e;

   typedef logic [NUM_PLAYERS-1:0][COUNT_W-1:0] counts_t;

   // One-hot player mask for a cell colour; non-player colours give zero.
   function automatic logic [NUM_PLAYERS-1:0] colour_hit(input logic [2:0] col);
      colour_hit = '0;
      case (col)
         P1_COL:  colour_hit[0] = 1'b1;
         P2_COL:  colour_hit[1] = 1'b1;
         P3_COL:  colour_hit[2] = 1'b1;
         P4_COL:  colour_hit[3] = 1'b1;
         default: colour_hit = '0;
      endcase
   endfunction

endpackage

// File: rtl/turf_winner_select.sv
// rtl/turf_winner_select.sv - combinational 4-way max with lowest-index tie resolution
module turf_winner_select
   import turf_pkg::*;
(
   input  counts_t counts,
   output winner_e winner,
   output logic    tie
);

   logic [COUNT_W-1:0] best;
   logic [2:0]         n_best;

   always_comb begin
      best   = counts[0];
      winner = WIN_P1;
      // Strict compare keeps the earliest player on equal counts.
      for (int i = 1; i < NUM_PLAYERS; i++) begin
         if (counts[i] > best) begin
            best   = counts[i];
            winner = winner_e'(i[1:0]);
         end
      end
      n_best = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (counts[i] == best) begin
            n_best = n_best + 3'd1;
         end
      end
      tie = (n_best > 3'd1);
   end

endmodule

// File: rtl/turf_tally.sv
// rtl/turf_tally.sv - board RAM territory scanner; TURF_TIE_DETECT_EN adds the tie output
module turf_tally
   import turf_pkg::*;
#(
   parameter int X_CELLS   = 160,
   parameter int SCAN_ROWS = 119
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic [2:0]         ram_q,
   output logic [ADDR_W-1:0]  address,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] p1_count,
   output logic [COUNT_W-1:0] p2_count,
   output logic [COUNT_W-1:0] p3_count,
   output logic [COUNT_W-1:0] p4_count,
   output logic [1:0]         winner
`ifdef TURF_TIE_DETECT_EN
   ,
   output logic               tie
`endif
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_CELLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCAN_ROWS - 1);

   state_e                  state_q, state_d;
   logic [X_W-1:0]          x_q, x_d;
   logic [Y_W-1:0]          y_q, y_d;
   logic                    last_q, last_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    data_valid_q, data_valid_d;
   counts_t                 acc_q, acc_d;
   counts_t                 pub_q, pub_d;
   winner_e                 win_q, win_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic [NUM_PLAYERS-1:0]  hit;
   winner_e                 sel_winner;
   logic                    sel_tie;

`ifdef TURF_TIE_DETECT_EN
   logic tie_q, tie_d;
`else
   logic sel_tie_unused;
   assign sel_tie_unused = sel_tie;
`endif

   turf_winner_select u_winner_select (
      .counts (acc_q),
      .winner (sel_winner),
      .tie    (sel_tie)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      last_d       = last_q;
      addr_d       = '0;
      rd_valid_d   = 1'b0;
      data_valid_d = rd_valid_q;
      acc_d        = acc_q;
      pub_d        = pub_q;
      win_d        = win_q;
      done_d       = 1'b0;
`ifdef TURF_TIE_DETECT_EN
      tie_d        = tie_q;
`endif

      // ram_q belongs to the address issued on the previous cycle.
      hit = data_valid_q ? colour_hit(ram_q) : '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (hit[i]) begin
            acc_d[i] = acc_q[i] + COUNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               x_d     = '0;
               y_d     = '0;
               last_d  = 1'b0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (last_q) begin
               state_d = S_DRAIN;
            end else begin
               addr_d     = {x_q, y_q};
               rd_valid_d = 1'b1;
               if (y_q == Y_LAST) begin
                  y_d = '0;
                  if (x_q == X_LAST) begin
                     last_d = 1'b1;
                  end else begin
                     x_d = x_q + X_W'(1);
                  end
               end else begin
                  y_d = y_q + Y_W'(1);
               end
            end
         end
         S_DRAIN: begin
            state_d = S_DECIDE;
         end
         S_DECIDE: begin
            pub_d   = acc_q;
            win_d   = sel_winner;
`ifdef TURF_TIE_DETECT_EN
            tie_d   = sel_tie;
`endif
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         last_q       <= 1'b0;
         addr_q       <= '0;
         rd_valid_q   <= 1'b0;
         data_valid_q <= 1'b0;
         acc_q        <= '0;
         pub_q        <= '0;
         win_q        <= WIN_P1;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
`ifdef TURF_TIE_DETECT_EN
         tie_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         last_q       <= last_d;
         addr_q       <= addr_d;
         rd_valid_q   <= rd_valid_d;
         data_valid_q <= data_valid_d;
         acc_q        <= acc_d;
         pub_q        <= pub_d;
         win_q        <= win_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
`ifdef TURF_TIE_DETECT_EN
         tie_q        <= tie_d;
`endif
      end
   end

   assign address  = addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign p1_count = pub_q[0];
   assign p2_count = pub_q[1];
   assign p3_count = pub_q[2];
   assign p4_count = pub_q[3];
   assign winner   = win_q;
`ifdef TURF_TIE_DETECT_EN
   assign tie      = tie_q;
`endif

endmodule

// File: doc/turf_tally.md
# turf_tally

Territory scanner for the Turf Wars game board. After the round timer expires, this block reads every playable cell of the 160x120 board RAM (3-bit colour per cell, address {x[7:0], y[6:0]}). It counts the cells owned by each of the four players and reports the per-player totals and the winner. It sits on the read port of the board RAM, opposite the pixel writer that paints player positions into that RAM and the VGA framebuffer.

## Interface
Parameters:
- X_CELLS, default 160: board width; x scans 0..X_CELLS-1.
- SCAN_ROWS, default 119: rows scanned, y = 0..SCAN_ROWS-1. Row 119 is the timer bar and is excluded.

Ports:
- CLOCK_50, in, 1: system clock. Single clock domain.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: begin a scan. Sampled only in IDLE.
- ram_q, in, 3: board RAM read data. Valid one cycle after `address`.
- address, out, 15: {x, y} read address to the board RAM.
- busy, out, 1: high from the cycle after `start` is accepted until `done`.
- done, out, 1: one-cycle pulse when results update.
- p1_count, p2_count, p3_count, p4_count, out, 15 each: published cell totals.
- winner, out, 2: 0 = P1, 1 = P2, 2 = P3, 3 = P4.
- tie, out, 1: present only with TURF_TIE_DETECT_EN.

## Operation
- Colour map: 001 = P1, 010 = P2, 100 = P3, 110 = P4. The values 000, 111, 011, 101 are not counted.
- FSM states: IDLE, SCAN, DRAIN, DECIDE.
- IDLE:
  - address = 0.
  - If `start` is high: clear all four accumulators, move to SCAN.
- SCAN:
  - One address per cycle, y-major: y increments; at SCAN_ROWS-1, y wraps to 0 and x increments.
  - After address {X_CELLS-1, SCAN_ROWS-1} is presented, move to DRAIN.
- DRAIN: one cycle to absorb the last RAM word.
- DECIDE:
  - Load published counts from the accumulators, load `winner`, pulse `done`.
  - Return to IDLE.
- Read pipeline:
  - A valid bit tracks each issued address.
  - `ram_q` is accumulated only when its valid bit is set, one cycle after the address was issued.
- Accumulators are 15 bits. The maximum count of 160*119 = 19040 fits, so no saturation logic.
- Published outputs hold the previous result for the whole scan. Only DECIDE changes them.
- Winner is the largest count. Ties resolve to the lowest player index.
- `start` while busy is ignored. A `start` high in the DECIDE cycle is ignored.
- Reset, including mid-scan:
  - All outputs and accumulators go to 0, state goes to IDLE, address = 0, valid bit cleared.
  - The reset value winner = 0 is not a valid result until the first `done`.

## Timing
- N = X_CELLS * SCAN_ROWS = 19040 by default.
- `start` sampled at edge 0 → address 0 presented after edge 1.
- Address N-1 presented after edge N.
- Last data accumulated at edge N+2.
- `done` and the new outputs are high/valid after edge N+3. `done` returns low after edge N+4.
- `busy` is high after edges 1 through N+2 and low in the `done` cycle.
- Earliest next `start` acceptance: the cycle in which `done` is high.
- Throughput: one cell per clock.

## Configuration
- TURF_TIE_DETECT_EN:
  - Defined: a `tie` port is added. It is loaded in DECIDE, high when two or more players share the maximum count (including all-zero). It resets to 0.
  - Undefined: no `tie` port; behaviour is otherwise identical, including lowest-index tie resolution for `winner`.

## Structure
- Shared package turf_pkg holds:
  - Player colour constants (P1_COL..P4_COL, TIMER_COL = 111, EMPTY_COL = 000).
  - X_W = 8, Y_W = 7, ADDR_W = 15, COUNT_W = 15.
  - Winner encoding.
- One sub-module, turf_winner_select: combinational 4-way max over the counts, producing winner and tie. It is instantiated once and registered in DECIDE.

## Test plan
Bench RAM model: 32768x3 array with one-cycle registered read.
- Reset check: assert reset asynchronously mid-cycle → all counts 0, winner 0, busy 0, done 0, address 0 immediately.
- Empty board: all cells 000, pulse `start` → `done` pulses exactly once, N+3 edges later. All counts 0, winner 0, tie = 1 with the macro.
- Striped board:
  - Fill: x<40 = 001, 40≤x<100 = 100, x≥100 = 010.
  - Expected: p1_count 4760, p2_count 7140, p3_count 7140, p4_count 0, winner 1, tie 1.
- Timer-row exclusion: row y=119 all 110, row y=0 all 111, rest 000 → all counts 0.
- Last-cell drain: only cell (159,118) = 110 → p4_count 1, winner 3. Then only cell (0,0) = 001 → p1_count 1, winner 0.
- Reset mid-scan and ignored start:
  - Assert reset at edge 5000 of a striped-board scan → outputs 0, no `done`.
  - Restart → correct striped result.
  - Extra `start` pulses during the scan cause no restart and no second `done`.
